qpsk_link_ctrl: RTL and testbench
=================================

Name: qpsk_link_ctrl

Overview:
Sequencing controller for the QPSK PRBS -> tx -> rx chain. It generates the symbol-rate tick that paces the PRBS9 source and brings the transmitter and receiver up in order. It waits out each filter's fill latency before declaring data valid, and applies receiver phase changes only on symbol boundaries. It sits between the board switches and the prbs9/tx/rx instances, replacing the ad hoc clock-divide enable.

Parameters:
OS, 4, oversampling factor (clock cycles per symbol), legal range 2..16
TX_FILL_SYM, 8, symbol ticks the tx filter needs before its output is meaningful, range 1..255
RX_FILL_SYM, 12, symbol ticks the rx chain needs after enable or phase change, range 1..255

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous reset, active-low
i_enable_tx  in  1  tx request (switch 0), level
i_enable_rx  in  1  rx request (switch 1), level
i_phase  in  2  requested rx downsampling phase (0..OS-1, values >= OS clamp to OS-1)
o_sym_tick  out  1  one-cycle symbol strobe, drives prbs9 enable
o_enable_tx  out  1  tx enable
o_enable_rx  out  1  rx enable
o_phase  out  2  applied rx phase
o_rx_valid  out  1  rx output trustworthy
o_state  out  3  FSM state code, for debug/ILA

Behaviour:
- All outputs are registered. On rst=0 at a clk edge: state=IDLE, os_cnt=0, fill_cnt=0, o_sym_tick=0, o_enable_tx=0, o_enable_rx=0, o_phase=0, o_rx_valid=0.
- States and o_state codes: IDLE=0, TX_FILL=1, TX_RUN=2, RX_FILL=3, RUN=4.
- Tick generator: os_cnt counts 0..OS-1 and wraps. It is held at 0 in IDLE. On the edge leaving IDLE, os_cnt<=1 and o_sym_tick<=1, so the first tick lands in the first TX_FILL cycle. After that, o_sym_tick=1 exactly when os_cnt wraps, i.e. one pulse every OS cycles with no gaps across state changes other than to IDLE.
- IDLE: all enables 0. If i_enable_tx=1, go to TX_FILL and clear fill_cnt.
- TX_FILL: o_enable_tx=1. fill_cnt increments on each tick cycle. On the edge that closes the TX_FILL_SYM-th tick cycle, go to TX_RUN and clear fill_cnt.
- TX_RUN: o_enable_tx=1. If i_enable_rx=1, go to RX_FILL and latch o_phase<=clamped i_phase on the same edge.
- RX_FILL: o_enable_tx=1, o_enable_rx=1, o_rx_valid=0. Count ticks as in TX_FILL. After the RX_FILL_SYM-th tick cycle, go to RUN.
- RUN: tx and rx enables = 1, o_rx_valid=1.
- Phase update: i_phase is sampled only on the edge closing a tick cycle, in RX_FILL or RUN.
  - If the clamped value differs from o_phase: o_phase updates, fill_cnt clears, state goes to (or stays in) RX_FILL, and o_rx_valid drops on that edge.
  - If equal: no effect.
  - i_phase changes between ticks are ignored.
- Priority per edge, highest first:
  1. rst
  2. i_enable_tx=0 in any non-IDLE state -> IDLE. All outputs return to reset values on that edge except o_phase, which holds.
  3. i_enable_rx=0 in RX_FILL/RUN -> TX_RUN: o_enable_rx=0, o_rx_valid=0, tick keeps running.
  4. phase change
  5. fill completion
- Simultaneous fill completion and phase change -> phase change wins (stay in RX_FILL, count restarts).
- fill_cnt is 8 bits and saturates; it never wraps.
- Reset mid-operation: the next cycle is indistinguishable from power-up.
- Re-entry: re-asserting i_enable_rx from TX_RUN always repeats the full RX_FILL wait.

Decomposition:
- Shared package qpsk_pkg: state encodings (ST_IDLE..ST_RUN), OS/fill default constants, and the phase width constant shared with rx.
- One sub-module: sym_tick_gen (os_cnt, wrap, load-on-start, tick output), reused by the top level in place of its current divider.
- The FSM and fill counter stay in qpsk_link_ctrl.

Test Plan:
- Reset, then enable_tx=1 at cycle 0 (OS=4, TX_FILL_SYM=3):
  - ticks at cycles 1, 5, 9, 13…
  - o_enable_tx=1 from cycle 1
  - o_state=2 from cycle 10
- From TX_RUN, enable_rx=1 with i_phase=2 (RX_FILL_SYM=12):
  - o_enable_rx=1 and o_phase=2 next cycle
  - o_rx_valid=1 exactly after 12 ticks, o_state=4
- In RUN, change i_phase 2->1 mid-symbol:
  - no change until the edge after the next tick
  - then o_phase=1, o_rx_valid=0, o_state=3
  - valid returns after 12 more ticks
- i_phase toggles 2->3->2 between ticks: no effect, o_rx_valid stays 1.
- In RUN, drop enable_tx: next cycle o_state=0, all enables/tick/valid = 0, o_phase held. Re-enable: first tick in the first TX_FILL cycle.
- Assert rst=0 for one cycle during RX_FILL, with phase change and fill completion forced on the same tick: reset values next cycle; in the separate run, state stays RX_FILL.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK link: controller state codes, default
// timing constants and the phase/fill helpers used by the controller and rx.
package qpsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_FILL = 3'd1,
    ST_TX_RUN  = 3'd2,
    ST_RX_FILL = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

  localparam int OS_DEF          = 4;
  localparam int TX_FILL_SYM_DEF = 8;
  localparam int RX_FILL_SYM_DEF = 12;
  localparam int PHASE_W         = 2;
  localparam int FILL_W          = 8;

  // Requested phases beyond the last sample slot collapse onto the last slot.
  function automatic logic [PHASE_W-1:0] clamp_phase(input logic [PHASE_W-1:0] p, input int os);
    if (int'(p) > os - 1) begin
      return PHASE_W'(os - 1);
    end else begin
      return p;
    end
  endfunction

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
    if (v == {FILL_W{1'b1}}) begin
      return v;
    end else begin
      return v + FILL_W'(1);
    end
  endfunction

endpackage

// File: rtl/sym_tick_gen.sv
// Symbol-rate strobe generator: one registered pulse every OS cycles, parked at
// zero while stopped and phase-aligned so the first pulse follows the start edge.
module sym_tick_gen #(
  parameter int OS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_start,
  output logic o_tick
);

  localparam int CW = (OS > 2) ? $clog2(OS) : 1;

  logic [CW-1:0] r_os_cnt;
  logic          r_tick;

  // Divider counter and registered strobe; loading 1 on start puts the pulse in the first run cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_os_cnt <= '0;
      r_tick   <= 1'b0;
    end else if (!i_run) begin
      r_os_cnt <= '0;
      r_tick   <= 1'b0;
    end else if (i_start) begin
      r_os_cnt <= CW'(1);
      r_tick   <= 1'b1;
    end else begin
      r_os_cnt <= (r_os_cnt == CW'(OS - 1)) ? '0 : r_os_cnt + CW'(1);
      r_tick   <= (r_os_cnt == '0);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/qpsk_link_ctrl.sv
// Bring-up sequencer for the PRBS -> tx -> rx chain: paces the source, waits out
// filter fill latency and applies rx phase changes only on symbol boundaries.
module qpsk_link_ctrl
  import qpsk_pkg::*;
#(
  parameter int OS          = OS_DEF,
  parameter int TX_FILL_SYM = TX_FILL_SYM_DEF,
  parameter int RX_FILL_SYM = RX_FILL_SYM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable_tx,
  input  logic               i_enable_rx,
  input  logic [PHASE_W-1:0] i_phase,
  output logic               o_sym_tick,
  output logic               o_enable_tx,
  output logic               o_enable_rx,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_rx_valid,
  output logic [2:0]         o_state
);

  localparam logic [FILL_W-1:0] TX_LAST = FILL_W'(TX_FILL_SYM - 1);
  localparam logic [FILL_W-1:0] RX_LAST = FILL_W'(RX_FILL_SYM - 1);

  state_e              r_state, w_nxt;
  logic [FILL_W-1:0]   r_fill_cnt, w_fill_nxt;
  logic [PHASE_W-1:0]  r_phase, w_phase_nxt, w_phase_req;
  logic                r_en_tx, r_en_rx, r_valid;
  logic                w_tick, w_run, w_start;

  assign w_phase_req = clamp_phase(i_phase, OS);
  assign w_run       = (w_nxt != ST_IDLE);
  assign w_start     = (r_state == ST_IDLE) && w_run;

  sym_tick_gen #(.OS(OS)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_run   (w_run),
    .i_start (w_start),
    .o_tick  (w_tick)
  );

  // Next-state decode: tx drop, rx drop, phase change, fill completion in that order.
  always_comb begin
    w_nxt       = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_phase_nxt = r_phase;
    if (r_state != ST_IDLE && !i_enable_tx) begin
      w_nxt      = ST_IDLE;
      w_fill_nxt = '0;
    end else if ((r_state == ST_RX_FILL || r_state == ST_RUN) && !i_enable_rx) begin
      w_nxt      = ST_TX_RUN;
      w_fill_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_enable_tx) begin
            w_nxt      = ST_TX_FILL;
            w_fill_nxt = '0;
          end else begin
            w_nxt = ST_IDLE;
          end
        end
        ST_TX_FILL: begin
          if (w_tick && r_fill_cnt >= TX_LAST) begin
            w_nxt      = ST_TX_RUN;
            w_fill_nxt = '0;
          end else if (w_tick) begin
            w_fill_nxt = fill_inc(r_fill_cnt);
          end else begin
            w_nxt = ST_TX_FILL;
          end
        end
        ST_TX_RUN: begin
          if (i_enable_rx) begin
            w_nxt       = ST_RX_FILL;
            w_fill_nxt  = '0;
            w_phase_nxt = w_phase_req;
          end else begin
            w_nxt = ST_TX_RUN;
          end
        end
        ST_RX_FILL, ST_RUN: begin
          if (w_tick && w_phase_req != r_phase) begin
            w_nxt       = ST_RX_FILL;
            w_fill_nxt  = '0;
            w_phase_nxt = w_phase_req;
          end else if (w_tick && r_state == ST_RX_FILL && r_fill_cnt >= RX_LAST) begin
            w_nxt      = ST_RUN;
            w_fill_nxt = '0;
          end else if (w_tick && r_state == ST_RX_FILL) begin
            w_fill_nxt = fill_inc(r_fill_cnt);
          end else begin
            w_nxt = r_state;
          end
        end
        default: begin
          w_nxt      = ST_IDLE;
          w_fill_nxt = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs derived from the decoded next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fill_cnt <= '0;
      r_phase    <= '0;
      r_en_tx    <= 1'b0;
      r_en_rx    <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_phase    <= w_phase_nxt;
      r_en_tx    <= w_run;
      r_en_rx    <= (w_nxt == ST_RX_FILL) || (w_nxt == ST_RUN);
      r_valid    <= (w_nxt == ST_RUN);
    end
  end

  assign o_sym_tick  = w_tick;
  assign o_enable_tx = r_en_tx;
  assign o_enable_rx = r_en_rx;
  assign o_phase     = r_phase;
  assign o_rx_valid  = r_valid;
  assign o_state     = r_state;

endmodule

// File: tb/tb_qpsk_link_ctrl.sv
// Bench for qpsk_link_ctrl: directed bring-up sequence with literal expectations,
// then random switch activity against a cycle model on two parameter sets.
module tb_qpsk_link_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_tx = 1'b0;
  logic       en_rx = 1'b0;
  logic [1:0] ph = 2'd0;

  logic       a_tick, a_etx, a_erx, a_vld;
  logic [1:0] a_ph;
  logic [2:0] a_st;
  logic       b_tick, b_etx, b_erx, b_vld;
  logic [1:0] b_ph;
  logic [2:0] b_st;

  int checks = 0;
  int errors = 0;
  int c = 0;

  always #5 clk = ~clk;

  qpsk_link_ctrl #(.OS(4), .TX_FILL_SYM(3), .RX_FILL_SYM(12)) dut_a (
    .clk(clk), .rst(rst), .i_enable_tx(en_tx), .i_enable_rx(en_rx), .i_phase(ph),
    .o_sym_tick(a_tick), .o_enable_tx(a_etx), .o_enable_rx(a_erx), .o_phase(a_ph),
    .o_rx_valid(a_vld), .o_state(a_st)
  );

  qpsk_link_ctrl #(.OS(2), .TX_FILL_SYM(1), .RX_FILL_SYM(1)) dut_b (
    .clk(clk), .rst(rst), .i_enable_tx(en_tx), .i_enable_rx(en_rx), .i_phase(ph),
    .o_sym_tick(b_tick), .o_enable_tx(b_etx), .o_enable_rx(b_erx), .o_phase(b_ph),
    .o_rx_valid(b_vld), .o_state(b_st)
  );

  // mode: 0 idle, 1 tx fill, 2 tx run, 3 rx fill, 4 run; t = cycles since leaving idle
  typedef struct {
    int mode;
    int t;
    int ticks;
    int phase;
  } mdl_t;

  mdl_t ma = '{0, 0, 0, 0};
  mdl_t mb = '{0, 0, 0, 0};

  function automatic bit m_tick(mdl_t m, int os);
    return (m.mode != 0) && ((m.t % os) == 0);
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit r, bit etx, bit erx, int p, int os, int txf, int rxf);
    mdl_t n = m;
    bit tk = m_tick(m, os);
    int cp = (p >= os) ? os - 1 : p;
    if (!r) begin
      n = '{0, 0, 0, 0};
    end else if (m.mode != 0 && !etx) begin
      n.mode = 0; n.t = 0; n.ticks = 0;
    end else if (m.mode == 0) begin
      if (etx) begin n.mode = 1; n.t = 0; n.ticks = 0; end
    end else begin
      n.t = m.t + 1;
      if (m.mode >= 3 && !erx) begin
        n.mode = 2; n.ticks = 0;
      end else if (m.mode == 2) begin
        if (erx) begin n.mode = 3; n.ticks = 0; n.phase = cp; end
      end else if (m.mode >= 3 && tk && cp != m.phase) begin
        n.mode = 3; n.ticks = 0; n.phase = cp;
      end else if ((m.mode == 1 || m.mode == 3) && tk) begin
        n.ticks = m.ticks + 1;
        if (n.ticks >= ((m.mode == 1) ? txf : rxf)) begin
          n.mode = m.mode + 1; n.ticks = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, c, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input int os, input logic tk,
                         input logic etx, input logic erx, input logic [1:0] p,
                         input logic vld, input logic [2:0] st);
    chk({tag, ".state"}, {29'd0, st}, m.mode);
    chk({tag, ".tick"}, {31'd0, tk}, {31'd0, m_tick(m, os)});
    chk({tag, ".en_tx"}, {31'd0, etx}, (m.mode != 0) ? 32'd1 : 32'd0);
    chk({tag, ".en_rx"}, {31'd0, erx}, (m.mode >= 3) ? 32'd1 : 32'd0);
    chk({tag, ".valid"}, {31'd0, vld}, (m.mode == 4) ? 32'd1 : 32'd0);
    chk({tag, ".phase"}, {30'd0, p}, m.phase);
  endtask

  // Model advances on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    ma = mstep(ma, rst, en_tx, en_rx, int'(ph), 4, 3, 12);
    mb = mstep(mb, rst, en_tx, en_rx, int'(ph), 2, 1, 1);
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp_dut("a", ma, 4, a_tick, a_etx, a_erx, a_ph, a_vld, a_st);
      cmp_dut("b", mb, 2, b_tick, b_etx, b_erx, b_ph, b_vld, b_st);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    c++;
  endtask

  initial begin
    repeat (3) next_cycle();
    chk("rst_state", {29'd0, a_st}, 32'd0);
    chk("rst_outs", {27'd0, a_tick, a_etx, a_erx, a_vld, 1'b0}, 32'd0);
    chk("rst_phase", {30'd0, a_ph}, 32'd0);

    rst = 1'b1; en_tx = 1'b1; c = 0;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      chk("tx_tick", {31'd0, a_tick}, (k == 1 || k == 5 || k == 9) ? 32'd1 : 32'd0);
      chk("tx_en", {31'd0, a_etx}, 32'd1);
      chk("tx_state", {29'd0, a_st}, (k >= 10) ? 32'd2 : 32'd1);
    end

    en_rx = 1'b1; ph = 2'd2;
    next_cycle();
    chk("rx_en", {31'd0, a_erx}, 32'd1);
    chk("rx_phase", {30'd0, a_ph}, 32'd2);
    while (c < 58) begin
      next_cycle();
      chk("rx_valid", {31'd0, a_vld}, (c >= 58) ? 32'd1 : 32'd0);
      chk("rx_state", {29'd0, a_st}, (c >= 58) ? 32'd4 : 32'd3);
    end

    ph = 2'd1;
    while (c < 62) begin
      next_cycle();
      chk("ph_phase", {30'd0, a_ph}, (c >= 62) ? 32'd1 : 32'd2);
      chk("ph_state", {29'd0, a_st}, (c >= 62) ? 32'd3 : 32'd4);
    end
    chk("ph_valid", {31'd0, a_vld}, 32'd0);
    while (c < 110) begin
      next_cycle();
      chk("ph_refill", {31'd0, a_vld}, (c >= 110) ? 32'd1 : 32'd0);
    end

    ph = 2'd3;
    while (c < 114) begin
      next_cycle();
      if (c == 111) ph = 2'd2;
      if (c == 112) ph = 2'd1;
      chk("glitch_valid", {31'd0, a_vld}, 32'd1);
      chk("glitch_phase", {30'd0, a_ph}, 32'd1);
    end

    en_tx = 1'b0;
    next_cycle();
    chk("drop_state", {29'd0, a_st}, 32'd0);
    chk("drop_outs", {28'd0, a_tick, a_etx, a_erx, a_vld}, 32'd0);
    chk("drop_phase", {30'd0, a_ph}, 32'd1);
    en_tx = 1'b1;
    next_cycle();
    chk("reen_tick", {31'd0, a_tick}, 32'd1);
    chk("reen_state", {29'd0, a_st}, 32'd1);

    while (c < 172) next_cycle();
    chk("coin_pre", {29'd0, a_st}, 32'd3);
    ph = 2'd2;
    next_cycle();
    chk("coin_state", {29'd0, a_st}, 32'd3);
    chk("coin_phase", {30'd0, a_ph}, 32'd2);
    chk("coin_valid", {31'd0, a_vld}, 32'd0);

    while (c < 220) next_cycle();
    ph = 2'd3; rst = 1'b0;
    next_cycle();
    chk("mrst_state", {29'd0, a_st}, 32'd0);
    chk("mrst_outs", {28'd0, a_tick, a_etx, a_erx, a_vld}, 32'd0);
    chk("mrst_phase", {30'd0, a_ph}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst = ($urandom_range(0, 199) != 0);
      if (en_tx) begin
        if ($urandom_range(0, 149) == 0) en_tx = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) en_tx = 1'b1;
      end
      if ($urandom_range(0, 79) == 0) en_rx = ~en_rx;
      if ($urandom_range(0, 99) == 0) ph = 2'($urandom_range(0, 3));
    end

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
